// File: rtl/megarom_mapper.sv
// MSX MegaROM mapper (Konami, Konami-SCC, ASCII8, ASCII16) with four 8 KB bank registers.
// Define MEGAROM_SCC_EN to decode the SCC register window (9800-9FFF) in Konami-SCC mode.
module megarom_mapper #(
  parameter int                ADDR_W    = 23,
  parameter int                BANK_BITS = 8,
  parameter logic [ADDR_W-1:0] BASE      = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [15:0]       addr,
  input  logic [7:0]        cdin,
  input  logic              merq_n,
  input  logic              iorq_n,
  input  logic              sltsl_n,
  input  logic              m1_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic              enable,
  input  logic [1:0]        mode,
  output logic              cart_ena,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              scc_sel
);
  typedef logic [3:0][BANK_BITS-1:0] bank_t;

  localparam logic [1:0] M_KON = 2'd0, M_SCC = 2'd1, M_A8 = 2'd2, M_A16 = 2'd3;

  bank_t                 bank;
  logic [1:0]            mode_q;
  logic                  wr_seen;
  logic [1:0]            idx;
  logic [1:0]            wr_idx;
  logic                  wr_hit;
  logic                  acc;
  logic [BANK_BITS-1:0]  rd_bank;
  logic [BANK_BITS+13:0] raw;
  logic                  unused_strobes;

  assign unused_strobes = &{1'b0, m1_n, rd_n};

  // Konami families power up with an identity map; ASCII families start all-zero.
  function automatic bank_t dflt(input logic [1:0] m);
    bank_t b;
    for (int i = 0; i < 4; i++) b[i] = m[1] ? '0 : BANK_BITS'(i);
    return b;
  endfunction

  assign cart_ena = enable & ~sltsl_n & ~merq_n & iorq_n &
                    (addr[15:14] == 2'b01 || addr[15:14] == 2'b10);
  assign idx      = addr[14:13] - 2'b10;

  always_comb begin
    rd_bank = bank[idx];
    if (mode_q == M_KON && idx == 2'd0) rd_bank = '0;
    if (mode_q == M_A16) raw = {bank[{addr[15], 1'b0}], addr[13:0]};
    else                 raw = {1'b0, rd_bank, addr[12:0]};
  end

  assign mem_addr = BASE + ADDR_W'(raw);

`ifdef MEGAROM_SCC_EN
  assign scc_sel = (mode_q == M_SCC) & cart_ena & (addr[15:11] == 5'b10011) &
                   (bank[2][5:0] == 6'h3F);
`else
  assign scc_sel = 1'b0;
`endif

  // Register-write decode; anything that misses leaves state untouched.
  always_comb begin
    wr_hit = 1'b0;
    wr_idx = idx;
    case (mode_q)
      M_KON: wr_hit = (idx != 2'd0);
      M_SCC: wr_hit = (addr[12:11] == 2'b10);
      M_A8: begin
        wr_hit = (addr[15:13] == 3'b011);
        wr_idx = addr[12:11];
      end
      default: begin
        wr_hit = (addr[15:13] == 3'b011) & ~addr[11];
        wr_idx = {addr[12], 1'b0};
      end
    endcase
    if (scc_sel) wr_hit = 1'b0;
  end

  assign acc = cart_ena & ~wr_n & ~wr_seen;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank    <= dflt(mode);
      mode_q  <= mode;
      wr_seen <= 1'b0;
    end else begin
      mode_q <= mode;
      if (acc)       wr_seen <= 1'b1;
      else if (wr_n) wr_seen <= 1'b0;
      // A mode change wins over a coincident write so the new map starts clean.
      if (mode != mode_q)    bank         <= dflt(mode);
      else if (acc && wr_hit) bank[wr_idx] <= BANK_BITS'(cdin);
    end
  end
endmodule

// File: tb/tb_megarom_mapper.sv
// Directed self-checking bench for megarom_mapper (default parameters).
module tb_megarom_mapper;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  cdin = 8'h00;
  logic        merq_n = 1'b1, iorq_n = 1'b1, sltsl_n = 1'b1, m1_n = 1'b1;
  logic        rd_n = 1'b1, wr_n = 1'b1, enable = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic        cart_ena;
  logic [22:0] mem_addr;
  logic        scc_sel;
  int          tests = 0;
  int          fails = 0;

  megarom_mapper dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .cdin(cdin), .merq_n(merq_n),
    .iorq_n(iorq_n), .sltsl_n(sltsl_n), .m1_n(m1_n), .rd_n(rd_n), .wr_n(wr_n),
    .enable(enable), .mode(mode), .cart_ena(cart_ena), .mem_addr(mem_addr),
    .scc_sel(scc_sel)
  );

  always #5 clk = ~clk;

  task automatic bus_idle();
    sltsl_n = 1'b1; merq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic apply_reset(input logic [1:0] m);
    @(negedge clk);
    bus_idle(); enable = 1'b1; iorq_n = 1'b1; mode = m; reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; cdin = d; sltsl_n = 1'b0; merq_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    bus_idle();
    @(negedge clk);
  endtask

  task automatic do_read(input logic [15:0] a);
    @(negedge clk);
    bus_idle();
    addr = a; sltsl_n = 1'b0; merq_n = 1'b0; rd_n = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    apply_reset(2'd0);
    tests++; if (cart_ena !== 1'b0) begin fails++; $display("FAIL rst_idle_ena got %b exp 0", cart_ena); end
    tests++; if (scc_sel !== 1'b0) begin fails++; $display("FAIL rst_scc got %b exp 0", scc_sel); end
    do_read(16'h8000);
    tests++; if (cart_ena !== 1'b1) begin fails++; $display("FAIL rst_8000_ena got %b exp 1", cart_ena); end
    tests++; if (mem_addr !== 23'h004000) begin fails++; $display("FAIL rst_8000 got %h exp 004000", mem_addr); end
    do_read(16'h6000);
    tests++; if (mem_addr !== 23'h002000) begin fails++; $display("FAIL rst_6000 got %h exp 002000", mem_addr); end
    do_read(16'hBFFF);
    tests++; if (mem_addr !== 23'h007FFF) begin fails++; $display("FAIL rst_bfff got %h exp 007fff", mem_addr); end
    do_read(16'hC000);
    tests++; if (cart_ena !== 1'b0) begin fails++; $display("FAIL rst_c000_ena got %b exp 0", cart_ena); end
    bus_idle();
  endtask

  task automatic test_konami();
    apply_reset(2'd0);
    do_write(16'h8000, 8'h05);
    do_read(16'h8123);
    tests++; if (mem_addr !== 23'h00A123) begin fails++; $display("FAIL kon_bank2 got %h exp 00a123", mem_addr); end
    do_write(16'h4000, 8'h09);
    do_read(16'h4000);
    tests++; if (mem_addr !== 23'h000000) begin fails++; $display("FAIL kon_bank0 got %h exp 000000", mem_addr); end
    bus_idle();
  endtask

  task automatic test_ascii8();
    apply_reset(2'd2);
    do_read(16'h7234);
    tests++; if (mem_addr !== 23'h001234) begin fails++; $display("FAIL a8_default got %h exp 001234", mem_addr); end
    do_write(16'h6800, 8'h05);
    do_read(16'h7234);
    tests++; if (mem_addr !== 23'h00B234) begin fails++; $display("FAIL a8_bank1 got %h exp 00b234", mem_addr); end
    // Long write: data changes while wr_n stays low; only the first value may land.
    @(negedge clk);
    bus_idle(); addr = 16'h6800; cdin = 8'h07; sltsl_n = 1'b0; merq_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    cdin = 8'h09;
    repeat (4) @(negedge clk);
    bus_idle();
    @(negedge clk);
    do_read(16'h7234);
    tests++; if (mem_addr !== 23'h00F234) begin fails++; $display("FAIL a8_hold got %h exp 00f234", mem_addr); end
    do_write(16'h6000, 8'h21);
    do_read(16'h4001);
    tests++; if (mem_addr !== 23'h042001) begin fails++; $display("FAIL a8_bank0 got %h exp 042001", mem_addr); end
    do_write(16'h7800, 8'h40);
    do_read(16'hBFFF);
    tests++; if (mem_addr !== 23'h081FFF) begin fails++; $display("FAIL a8_bank3 got %h exp 081fff", mem_addr); end
    bus_idle();
  endtask

  task automatic test_ascii16();
    apply_reset(2'd3);
    do_write(16'h7000, 8'h03);
    do_read(16'h9ABC);
    tests++; if (mem_addr !== 23'h00DABC) begin fails++; $display("FAIL a16_9abc got %h exp 00dabc", mem_addr); end
    do_read(16'h4000);
    tests++; if (mem_addr !== 23'h000000) begin fails++; $display("FAIL a16_4000 got %h exp 000000", mem_addr); end
    do_write(16'h6000, 8'h12);
    do_read(16'h7FFF);
    tests++; if (mem_addr !== 23'h04BFFF) begin fails++; $display("FAIL a16_7fff got %h exp 04bfff", mem_addr); end
    do_write(16'h6800, 8'h55);
    do_read(16'h4000);
    tests++; if (mem_addr !== 23'h048000) begin fails++; $display("FAIL a16_ign got %h exp 048000", mem_addr); end
    bus_idle();
  endtask

  task automatic test_mode_switch();
    apply_reset(2'd1);
    do_read(16'h6000);
    tests++; if (mem_addr !== 23'h002000) begin fails++; $display("FAIL scc_default got %h exp 002000", mem_addr); end
    do_write(16'h5000, 8'h0A);
    do_read(16'h4000);
    tests++; if (mem_addr !== 23'h014000) begin fails++; $display("FAIL scc_bank0 got %h exp 014000", mem_addr); end
    do_write(16'h5800, 8'h33);
    do_read(16'h4000);
    tests++; if (mem_addr !== 23'h014000) begin fails++; $display("FAIL scc_ign got %h exp 014000", mem_addr); end
    // Write presented on the same edge the mode changes.
    @(negedge clk);
    bus_idle(); mode = 2'd2; addr = 16'h6000; cdin = 8'h44;
    sltsl_n = 1'b0; merq_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus_idle();
    @(negedge clk);
    do_read(16'h4000);
    tests++; if (mem_addr !== 23'h000000) begin fails++; $display("FAIL sw_bank0 got %h exp 000000", mem_addr); end
    do_read(16'h6123);
    tests++; if (mem_addr !== 23'h000123) begin fails++; $display("FAIL sw_bank1 got %h exp 000123", mem_addr); end
    bus_idle();
  endtask

  task automatic test_enable_reset();
    apply_reset(2'd2);
    @(negedge clk);
    enable = 1'b0; addr = 16'h6000; cdin = 8'h11; sltsl_n = 1'b0; merq_n = 1'b0; wr_n = 1'b0;
    #1;
    tests++; if (cart_ena !== 1'b0) begin fails++; $display("FAIL en_ena got %b exp 0", cart_ena); end
    @(negedge clk);
    bus_idle(); enable = 1'b1;
    @(negedge clk);
    iorq_n = 1'b0; addr = 16'h6000; cdin = 8'h12; sltsl_n = 1'b0; merq_n = 1'b0; wr_n = 1'b0;
    #1;
    tests++; if (cart_ena !== 1'b0) begin fails++; $display("FAIL iorq_ena got %b exp 0", cart_ena); end
    @(negedge clk);
    bus_idle(); iorq_n = 1'b1;
    do_read(16'h4000);
    tests++; if (mem_addr !== 23'h000000) begin fails++; $display("FAIL en_nochg got %h exp 000000", mem_addr); end
    do_write(16'h6000, 8'h22);
    do_read(16'h4000);
    tests++; if (mem_addr !== 23'h044000) begin fails++; $display("FAIL en_wr got %h exp 044000", mem_addr); end
    // Reset lands before the write strobe reaches an edge.
    @(negedge clk);
    bus_idle(); addr = 16'h6000; cdin = 8'h33; sltsl_n = 1'b0; merq_n = 1'b0; wr_n = 1'b0;
    #2 reset_n = 1'b0;
    @(negedge clk);
    bus_idle();
    @(negedge clk);
    reset_n = 1'b1;
    do_read(16'h4000);
    tests++; if (mem_addr !== 23'h000000) begin fails++; $display("FAIL rst_mid got %h exp 000000", mem_addr); end
    bus_idle();
  endtask

  task automatic test_scc_window();
    apply_reset(2'd1);
    do_write(16'h9000, 8'h3F);
    do_read(16'h9810);
    tests++; if (mem_addr !== 23'h07F810) begin fails++; $display("FAIL scc_map got %h exp 07f810", mem_addr); end
`ifdef MEGAROM_SCC_EN
    tests++; if (scc_sel !== 1'b1) begin fails++; $display("FAIL scc_sel got %b exp 1", scc_sel); end
    do_write(16'h9810, 8'h11);
    do_read(16'h9000);
    tests++; if (mem_addr !== 23'h07E000) begin fails++; $display("FAIL scc_keep got %h exp 07e000", mem_addr); end
    tests++; if (scc_sel !== 1'b0) begin fails++; $display("FAIL scc_sel_off got %b exp 0", scc_sel); end
`else
    tests++; if (scc_sel !== 1'b0) begin fails++; $display("FAIL scc_tied got %b exp 0", scc_sel); end
`endif
    bus_idle();
  endtask

  initial begin
    test_reset();
    test_konami();
    test_ascii8();
    test_ascii16();
    test_mode_switch();
    test_enable_reset();
    test_scc_window();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/megarom_mapper.md
Name: megarom_mapper

Overview:
- Parametrised, multi-mode MSX MegaROM mapper.
- Decodes cartridge slot accesses in 4000h-BFFFh and holds four bank registers, one per 8 KB window.
- Translates Z80 addresses into a flat external-memory address.
- Supports Konami, Konami-SCC, ASCII8 and ASCII16 mapper schemes, selected at run time by a mode input.

Parameters:
- ADDR_W, 23: width of mem_addr.
- BANK_BITS, 8: width of each bank register. Bits of cdin above BANK_BITS are discarded.
- BASE, 0: offset added to every generated mem_addr. Sum truncated to ADDR_W bits.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- addr  in  16  Z80 address bus.
- cdin  in  8  Z80 data bus (write data).
- merq_n  in  1  memory request, active low.
- iorq_n  in  1  I/O request, active low.
- sltsl_n  in  1  slot select, active low.
- m1_n  in  1  opcode fetch, active low. Unused; present for bus uniformity.
- rd_n  in  1  read strobe, active low.
- wr_n  in  1  write strobe, active low.
- enable  in  1  mapper enable. When low, no decode and no bank writes.
- mode  in  2  mapper type: 0 Konami, 1 Konami-SCC, 2 ASCII8, 3 ASCII16.
- cart_ena  out  1  access hits this cartridge.
- mem_addr  out  ADDR_W  translated memory address.
- scc_sel  out  1  access hits the SCC register window (see Optional Feature).

Behaviour:
- Decode (combinational): cart_ena = enable & ~sltsl_n & ~merq_n & iorq_n & (addr[15:14] == 01 or 10).
- Windows: W0 = 4000-5FFF, W1 = 6000-7FFF, W2 = 8000-9FFF, W3 = A000-BFFF. Window index = addr[14:13] - 2'b10 (mod 4).
- 8 KB modes (0, 1, 2): mem_addr = BASE + {bank[idx], addr[12:0]}.
- ASCII16 (mode 3): 4000-7FFF uses bank[0], 8000-BFFF uses bank[2]; mem_addr = BASE + {bank, addr[13:0]}.
- Mode 0 forces bank[0] to read as 0 regardless of register content.
- mem_addr and scc_sel are combinational from addr and the bank registers.
- Write acceptance: a write is accepted on the first clk edge where enable & cart_ena & ~wr_n & ~wr_seen.
  - wr_seen sets on acceptance and clears on the first edge with wr_n high.
  - A single bus write updates a register exactly once, however many clocks wr_n stays low.
- Write targets (registers update at the acceptance edge; new mapping visible the next cycle):
  - Mode 0: 6000-7FFF -> bank1; 8000-9FFF -> bank2; A000-BFFF -> bank3; 4000-5FFF ignored.
  - Mode 1: 5000-57FF -> bank0; 7000-77FF -> bank1; 9000-97FF -> bank2; B000-B7FF -> bank3.
  - Mode 2: 6000-67FF -> bank0; 6800-6FFF -> bank1; 7000-77FF -> bank2; 7800-7FFF -> bank3.
  - Mode 3: 6000-67FF -> bank0; 7000-77FF -> bank2.
  - Any other decoded write is ignored and changes no state.
- Register defaults: modes 0/1 load bank0..3 = 0,1,2,3; modes 2/3 load all banks = 0.
- Reset: defaults for the mode sampled at reset; mode_q <= mode; wr_seen <= 0.
  - Asserting reset mid-write aborts the write; no partial update.
- Mode change: mode is registered into mode_q every cycle. On the edge where mode != mode_q:
  - banks reload defaults of the new mode;
  - any write acceptance on that edge is suppressed, but wr_seen still sets.
- Simultaneous enable deassert and write: no update.

Optional Feature:
- Macro: MEGAROM_SCC_EN.
- Defined: in mode 1, scc_sel = cart_ena & addr in 9800-9FFF & bank[2][5:0] == 6'h3F.
  - Writes in 9800-9FFF while scc_sel is high do not update any bank register.
- Undefined: scc_sel is tied 0 and the SCC window gets no special treatment.

Test Plan:
- Reset, mode=0, read 8000h (sltsl_n=0, merq_n=0) -> cart_ena=1, mem_addr=0x004000 (bank2 = 2).
- Mode 2, write 0x05 to 6800h, read 7234h -> mem_addr=0x00B234. Hold wr_n low 5 clk -> bank1 written once.
- Mode 3, write 0x03 to 7000h, read 9ABCh -> mem_addr=0x00DABC. Read 4000h -> mem_addr=0x000000.
- Mode 1, write 0x0A to 5000h -> 4000h maps to 0x014000. Switch to mode 2 -> bank0 reloads 0, and a write on the switch edge is ignored.
- enable=0 or iorq_n=0, write 6000h -> cart_ena=0, no register change. Assert reset_n mid-write -> defaults restored.
- MEGAROM_SCC_EN, mode 1, write 0x3F to 9000h, read 9810h -> scc_sel=1. Write 0x11 to 9810h -> bank2 remains 0x3F.
